// File: rtl/lc3_latency_memory_if.sv
// Request/complete bus between an LC3-style controller and lc3_latency_memory.
// With LC3_MEM_ERR_EN defined the bus carries an extra err flag.
interface lc3_latency_memory_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              req;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              complete;
`ifdef LC3_MEM_ERR_EN
  logic              err;
`endif

  // Requester side
  modport master (
    output req, rd, addr, din,
`ifdef LC3_MEM_ERR_EN
    input  err,
`endif
    input  dout, complete
  );

  // Memory side
  modport slave (
    input  req, rd, addr, din,
`ifdef LC3_MEM_ERR_EN
    output err,
`endif
    output dout, complete
  );
endinterface

// File: rtl/lc3_latency_memory.sv
// Bench memory with configurable read/write latency and a request/complete
// handshake. Contents live in the array "ram" for hierarchical preload.
// Optional feature macro: LC3_MEM_ERR_EN (out-of-range accesses flag err
// instead of wrapping modulo DEPTH).
module lc3_latency_memory #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 65536,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned WR_LAT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  lc3_latency_memory_if.slave  bus
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  logic [DATA_W-1:0] ram [DEPTH];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ram_we;
  logic [IDX_W-1:0]  idx;
  logic              unused_addr_bits;

`ifdef LC3_MEM_ERR_EN
  logic              err_q, err_d;
  logic              in_range;
  assign in_range = (64'(addr_q) < 64'(DEPTH));
`endif

  // Word index is the low bits of the latched address
  assign idx = addr_q[IDX_W-1:0];
  assign unused_addr_bits = ^{1'b0, addr_q};

  // State and latched request registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rd_q    <= 1'b0;
      dout_q  <= '0;
`ifdef LC3_MEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      dout_q  <= dout_d;
`ifdef LC3_MEM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next state: accept in IDLE, count down in BUSY, access on the last edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rd_d    = rd_q;
    dout_d  = dout_q;
    ram_we  = 1'b0;
`ifdef LC3_MEM_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addr;
          din_d   = bus.din;
          rd_d    = bus.rd;
          cnt_d   = bus.rd ? CNT_W'(RD_LAT - 1) : CNT_W'(WR_LAT - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
`ifdef LC3_MEM_ERR_EN
          err_d = !in_range;
          if (rd_q) dout_d = in_range ? ram[idx] : '0;
          else      ram_we = in_range;
`else
          if (rd_q) dout_d = ram[idx];
          else      ram_we = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage write; enable comes from reset-cleared state so a reset
  // during BUSY abandons the write
  always_ff @(posedge clock) begin
    if (ram_we) ram[idx] <= din_q;
  end

  assign bus.complete = (state_q == ST_IDLE);
  assign bus.dout     = dout_q;
`ifdef LC3_MEM_ERR_EN
  assign bus.err      = err_q;
`endif

endmodule

// File: tb/tb_lc3_latency_memory.sv
// Self-checking bench for lc3_latency_memory: a default-latency 64K instance
// and a 16-word instance with RD_LAT=4 / WR_LAT=2.
module tb_lc3_latency_memory;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

`ifdef LC3_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  lc3_latency_memory_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
  lc3_latency_memory_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

  lc3_latency_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(65536), .RD_LAT(1), .WR_LAT(1))
    u_a (.clock(clock), .reset(reset), .bus(bus_a.slave));
  lc3_latency_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .RD_LAT(4), .WR_LAT(2))
    u_b (.clock(clock), .reset(reset), .bus(bus_b.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the 16-word instance
  logic [15:0] mem_b [16];
  logic [15:0] last_dout_b;

  typedef struct {
    int          sel;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] din;
    int          lat;
    logic [15:0] dout;
    logic        err;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Model of one access on the 16-word instance, from the access rules
  task automatic model_b(input logic rd, input logic [15:0] addr, input logic [15:0] din,
                         output logic [15:0] exp_dout, output logic exp_err, output int exp_lat);
    bit oor;
    int i;
    oor     = (int'(addr) >= 16);
    i       = int'(addr) % 16;
    exp_lat = rd ? 4 : 2;
    exp_err = ERR_EN && oor;
    if (rd) begin
      last_dout_b = (ERR_EN && oor) ? 16'h0000 : mem_b[i];
    end else if (!(ERR_EN && oor)) begin
      mem_b[i] = din;
    end
    exp_dout = last_dout_b;
  endtask

  // One handshake: pulse req, scramble inputs while busy, count busy edges
  task automatic acc(input int sel, input logic rd, input logic [15:0] addr, input logic [15:0] din,
                     output int lat, output logic [15:0] dout_o, output logic err_o);
    @(negedge clock);
    if (sel == 0) begin
      bus_a.req = 1'b1; bus_a.rd = rd; bus_a.addr = addr; bus_a.din = din;
    end else begin
      bus_b.req = 1'b1; bus_b.rd = rd; bus_b.addr = addr; bus_b.din = din;
    end
    @(posedge clock); #1;
    if (sel == 0) begin
      bus_a.req = 1'b0; bus_a.rd = 1'($urandom); bus_a.addr = 16'($urandom); bus_a.din = 16'($urandom);
    end else begin
      bus_b.req = 1'b0; bus_b.rd = 1'($urandom); bus_b.addr = 16'($urandom); bus_b.din = 16'($urandom);
    end
    lat = 0;
    while ((((sel == 0) ? bus_a.complete : bus_b.complete) == 1'b0) && (lat < 20)) begin
      lat++;
      @(posedge clock); #1;
    end
    dout_o = (sel == 0) ? bus_a.dout : bus_b.dout;
`ifdef LC3_MEM_ERR_EN
    err_o = (sel == 0) ? bus_a.err : bus_b.err;
`else
    err_o = 1'b0;
`endif
  endtask

  initial begin
    int          lat;
    logic [15:0] d;
    logic        e;
    logic [15:0] ed;
    logic        ee;
    int          el;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] din;

    bus_a.req = 1'b0; bus_a.rd = 1'b0; bus_a.addr = '0; bus_a.din = '0;
    bus_b.req = 1'b0; bus_b.rd = 1'b0; bus_b.addr = '0; bus_b.din = '0;
    last_dout_b = 16'h0000;

    // Reset values
    #2;
    chk("rst_complete_a", 32'(bus_a.complete), 32'd1);
    chk("rst_dout_a", 32'(bus_a.dout), 32'd0);
    chk("rst_complete_b", 32'(bus_b.complete), 32'd1);
    chk("rst_dout_b", 32'(bus_b.dout), 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    // Preload the small instance through the bus
    for (int i = 0; i < 16; i++) begin
      din = 16'hA000 + 16'(i);
      acc(1, 1'b0, 16'(i), din, lat, d, e);
      model_b(1'b0, 16'(i), din, ed, ee, el);
      chk("preload_lat", 32'(lat), 32'(el));
    end

    // Directed vectors
    vecs[0]  = '{0, 1'b0, 16'h3009, 16'h0023, 1, 16'h0000, 1'b0};
    vecs[1]  = '{0, 1'b0, 16'h300a, 16'h0024, 1, 16'h0000, 1'b0};
    vecs[2]  = '{0, 1'b1, 16'h3009, 16'h0000, 1, 16'h0023, 1'b0};
    vecs[3]  = '{0, 1'b0, 16'h300b, 16'h5555, 1, 16'h0023, 1'b0};
    vecs[4]  = '{0, 1'b1, 16'h300a, 16'h0000, 1, 16'h0024, 1'b0};
    vecs[5]  = '{0, 1'b1, 16'h300b, 16'h0000, 1, 16'h5555, 1'b0};
    vecs[6]  = '{1, 1'b0, 16'h000c, 16'h0024, 2, 16'h0000, 1'b0};
    vecs[7]  = '{1, 1'b1, 16'h000c, 16'h0000, 4, 16'h0024, 1'b0};
    vecs[8]  = '{1, 1'b0, 16'h0013, 16'hBEEF, 2, 16'h0024, ERR_EN};
    vecs[9]  = '{1, 1'b1, 16'h0003, 16'h0000, 4, ERR_EN ? 16'hA003 : 16'hBEEF, 1'b0};
    vecs[10] = '{1, 1'b1, 16'h0013, 16'h0000, 4, ERR_EN ? 16'h0000 : 16'hBEEF, ERR_EN};
    vecs[11] = '{1, 1'b1, 16'h0005, 16'h0000, 4, 16'hA005, 1'b0};

    for (int v = 0; v < 12; v++) begin
      acc(vecs[v].sel, vecs[v].rd, vecs[v].addr, vecs[v].din, lat, d, e);
      if (vecs[v].sel == 1) model_b(vecs[v].rd, vecs[v].addr, vecs[v].din, ed, ee, el);
      chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].lat));
      chk($sformatf("vec%0d_dout", v), 32'(d), 32'(vecs[v].dout));
      chk($sformatf("vec%0d_err", v), 32'(e), 32'(vecs[v].err));
    end

    // Held req: accepted at edges 0 and 2, one idle cycle between
    @(negedge clock);
    bus_a.req = 1'b1; bus_a.rd = 1'b1; bus_a.addr = 16'h3009;
    @(posedge clock); #1;
    chk("b2b_busy0", 32'(bus_a.complete), 32'd0);
    @(posedge clock); #1;
    chk("b2b_idle1", 32'(bus_a.complete), 32'd1);
    chk("b2b_dout1", 32'(bus_a.dout), 32'h0023);
    bus_a.addr = 16'h300a;
    @(posedge clock); #1;
    chk("b2b_busy2", 32'(bus_a.complete), 32'd0);
    chk("b2b_hold2", 32'(bus_a.dout), 32'h0023);
    @(posedge clock); #1;
    chk("b2b_idle3", 32'(bus_a.complete), 32'd1);
    chk("b2b_dout3", 32'(bus_a.dout), 32'h0024);
    bus_a.req = 1'b0;

    // Reset during a write abandons it; outputs clear without a clock edge
    acc(1, 1'b1, 16'h0005, 16'h0000, lat, d, e);
    model_b(1'b1, 16'h0005, 16'h0000, ed, ee, el);
    chk("pre_rst_dout", 32'(d), 32'(ed));
    @(negedge clock);
    bus_b.req = 1'b1; bus_b.rd = 1'b0; bus_b.addr = 16'h000b; bus_b.din = 16'h1234;
    @(posedge clock); #1;
    bus_b.req = 1'b0;
    @(posedge clock); #2;
    chk("mid_busy", 32'(bus_b.complete), 32'd0);
    reset = 1'b1;
    #1;
    chk("async_rst_complete", 32'(bus_b.complete), 32'd1);
    chk("async_rst_dout", 32'(bus_b.dout), 32'd0);
    last_dout_b = 16'h0000;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    acc(1, 1'b1, 16'h000b, 16'h0000, lat, d, e);
    model_b(1'b1, 16'h000b, 16'h0000, ed, ee, el);
    chk("rst_no_write", 32'(d), 32'(ed));

    // Randomized accesses against the model
    for (int n = 0; n < 40; n++) begin
      rd   = 1'($urandom);
      addr = 16'($urandom_range(0, 31));
      din  = 16'($urandom);
      acc(1, rd, addr, din, lat, d, e);
      model_b(rd, addr, din, ed, ee, el);
      chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(el));
      chk($sformatf("rnd%0d_dout", n), 32'(d), 32'(ed));
      chk($sformatf("rnd%0d_err", n), 32'(e), 32'(ee));
`ifdef LC3_MEM_ERR_EN
      if (ee) begin
        @(posedge clock); #1;
        chk($sformatf("rnd%0d_err_drop", n), 32'(bus_b.err), 32'd0);
      end
`endif
    end

    // Full readback of the small instance
    for (int i = 0; i < 16; i++) begin
      acc(1, 1'b1, 16'(i), 16'h0000, lat, d, e);
      model_b(1'b1, 16'(i), 16'h0000, ed, ee, el);
      chk($sformatf("readback%0d", i), 32'(d), 32'(ed));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_latency_memory.md
Name: lc3_latency_memory

Overview:
- Parametrised successor to the single-cycle, always-complete bench memory used with SimpleLC3.
- Adds configurable data/address width and depth, independent read and write latencies, and a real request/complete handshake.
- Lets the LC3 controller's memory-wait states be exercised under multi-cycle access.
- Sits beside the DUT in the bench; contents are preloaded by hierarchical $readmemh into the array named ram.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, address width
DEPTH, 65536, number of words; must be a power of two and no greater than 2**ADDR_W
RD_LAT, 1, clock edges from request acceptance to read completion; must be at least 1
WR_LAT, 1, clock edges from request acceptance to write completion; must be at least 1

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  access request; sampled only in IDLE
rd  input  1  1 = read, 0 = write; latched with req
addr  input  ADDR_W  word address; latched with req
din  input  DATA_W  write data; latched with req
dout  output  DATA_W  read data; registered
complete  output  1  1 = idle and ready, or last access finished; 0 = access in progress

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE, complete=1, dout=0, latency counter=0, latched address/data/rd=0.
  - ram contents are not cleared.
- States:
  - IDLE: complete=1. At a rising edge with req=1:
    - latch addr, din, rd;
    - load counter with (rd ? RD_LAT : WR_LAT) - 1;
    - go to BUSY; complete=0 after that edge.
  - BUSY: complete=0; req, rd, addr and din are ignored.
    - At each edge with counter != 0: counter decrements.
    - At the edge with counter == 0, perform the access:
      - read: dout <= ram[idx];
      - write: ram[idx] <= latched din; dout unchanged.
    - Return to IDLE; complete=1 after that edge.
- Latency: the request accepted at edge k completes at edge k+LAT. With LAT=1 this matches the legacy timing of data valid after the next edge, except that complete drops for one cycle.
- Back-to-back: a req present at the completing edge is not accepted. If req is held high, the next access is accepted at edge k+LAT+1, so there is one idle cycle with complete=1 between accesses.
- dout holds its last read value until the next read completes.
- Index: idx = latched addr modulo DEPTH (low log2(DEPTH) bits) when MEM_ERR_EN is undefined.
- Reset during BUSY: the access is abandoned and no ram write occurs. Outputs take their reset values immediately, without waiting for a clock edge.
- X on rd/addr/din while IDLE and req=0: no effect.

Optional Feature:
- Macro: LC3_MEM_ERR_EN.
- Defined:
  - adds output err (1 bit), reset 0;
  - an access with latched addr >= DEPTH completes at normal latency with err=1 for exactly one cycle, concurrent with complete rising;
  - an out-of-range read loads dout with 0; an out-of-range write leaves ram unmodified;
  - in-range accesses keep err=0.
- Undefined: no err port; out-of-range addresses wrap modulo DEPTH as stated above.

Test Plan:
1. Defaults (RD_LAT=WR_LAT=1), ram[3009]=0023. Pulse req rd=1 addr=3009 at edge k -> complete=0 for one cycle; at edge k+1 dout=0023 and complete=1.
2. RD_LAT=4, WR_LAT=2. Write 0024 to 300c, then read 300c -> complete low 2 cycles for the write and 4 cycles for the read; dout=0024. Changes to addr/din during BUSY have no effect.
3. Hold req=1 with rd=1, addr=3009 then 300a (ram 0023/0024), RD_LAT=1 -> accepted at edges 0 and 2; dout=0023 after edge 1, 0024 after edge 3.
4. WR_LAT=3. Write 1234 to 300b; assert reset 1 cycle after acceptance -> complete=1 and dout=0 asynchronously; ram[300b] keeps its preloaded value.
5. DEPTH=16, macro undefined. Write BEEF to addr 0013 -> ram[3]=BEEF; a read of 0003 returns BEEF.
6. DEPTH=16, LC3_MEM_ERR_EN defined. Read 0013 -> dout=0 and err=1 for one cycle coinciding with complete rising; a write to 0013 leaves all ram unchanged and gives err=1; an in-range read gives err=0.
